// File: rtl/centroid_defuzz.sv
// Sequential centroid defuzzifier: accumulates (mu, z) terms of a frame,
// divides sum(mu*z) by sum(mu) with a bit-serial restoring divider and
// presents a saturated signed Q7.0 result over a valid/ready handshake.
module centroid_defuzz #(
    parameter int unsigned MAX_TERMS = 16,
    parameter int unsigned DIV_BITS  = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_mu,
    input  logic [7:0]  in_z,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_y,
    output logic        out_zero,
    output logic        out_trunc
);

    localparam int unsigned CW = $clog2(MAX_TERMS);
    localparam int unsigned NW = 24 + CW;
    localparam int unsigned DW = 15 + CW;
    localparam int unsigned SW = $clog2(DIV_BITS + 1);

    typedef enum logic [1:0] {S_ACC, S_DIV, S_OUT} state_t;

    state_t                state, state_next;
    logic signed [NW-1:0]  num;
    logic [DW-1:0]         den;
    logic [CW-1:0]         cnt;
    logic                  trunc;
    logic                  sign;
    logic                  zero;
    logic [NW-1:0]         rem;
    logic [DIV_BITS-1:0]   quo;
    logic [SW-1:0]         div_cnt;

    logic [14:0]           mu_c;
    logic signed [23:0]    prod;
    logic                  at_limit;
    logic                  div_last;
    logic [SW-1:0]         bit_idx;
    logic [NW-1:0]         trial;
    logic                  ge;
    logic [DIV_BITS-1:0]   quo_next;
    logic [7:0]            y_next;

    // Term arithmetic, one divider step and result saturation
    always_comb begin
        mu_c     = (in_mu > 16'h7FFF) ? 15'h7FFF : in_mu[14:0];
        prod     = $signed({9'd0, mu_c}) * $signed({{16{in_z[7]}}, in_z});
        at_limit = (cnt == CW'(MAX_TERMS - 1));
        div_last = (div_cnt == SW'(DIV_BITS));
        // div_cnt 1..DIV_BITS walks quotient bits MSB first
        bit_idx  = SW'(DIV_BITS) - div_cnt;
        trial    = NW'(den) << bit_idx;
        ge       = (rem >= trial);
        quo_next = {quo[DIV_BITS-2:0], ge};
        y_next   = '0;
        if (zero) begin
            y_next = '0;
        end else if (sign) begin
            y_next = (quo_next > DIV_BITS'(128)) ? 8'h80 : (8'd0 - quo_next[7:0]);
        end else begin
            y_next = (quo_next > DIV_BITS'(127)) ? 8'h7F : quo_next[7:0];
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_ACC;
        else        state <= state_next;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            S_ACC: begin
                in_ready = 1'b1;
                if (in_valid && (in_last || at_limit)) state_next = S_DIV;
            end
            S_DIV: begin
                if (div_last) state_next = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_next = S_ACC;
            end
            default: state_next = S_ACC;
        endcase
    end

    // Accumulators, divider datapath and registered result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num       <= '0;
            den       <= '0;
            cnt       <= '0;
            trunc     <= 1'b0;
            sign      <= 1'b0;
            zero      <= 1'b0;
            rem       <= '0;
            quo       <= '0;
            div_cnt   <= '0;
            out_y     <= '0;
            out_zero  <= 1'b0;
            out_trunc <= 1'b0;
        end else begin
            case (state)
                S_ACC: begin
                    if (in_valid) begin
                        num <= num + NW'(prod);
                        den <= den + DW'(mu_c);
                        cnt <= cnt + CW'(1);
                        if (at_limit && !in_last) trunc <= 1'b1;
                    end
                end
                S_DIV: begin
                    if (div_cnt == '0) begin
                        sign    <= num[NW-1];
                        rem     <= num[NW-1] ? $unsigned(-num) : $unsigned(num);
                        zero    <= (den == '0);
                        quo     <= '0;
                        div_cnt <= div_cnt + SW'(1);
                    end else begin
                        if (ge) rem <= rem - trial;
                        quo <= quo_next;
                        if (div_last) begin
                            div_cnt   <= '0;
                            out_y     <= y_next;
                            out_zero  <= zero;
                            out_trunc <= trunc;
                        end else begin
                            div_cnt <= div_cnt + SW'(1);
                        end
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        num   <= '0;
                        den   <= '0;
                        cnt   <= '0;
                        trunc <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_centroid_defuzz.sv
// Self-checking bench for centroid_defuzz: a frame-level reference model
// pushes expected results into a scoreboard queue as terms are accepted;
// each scenario task pops and compares when the DUT presents a result.
module tb_centroid_defuzz;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_mu = '0;
    logic [7:0]  in_z = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_y;
    logic        out_zero;
    logic        out_trunc;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0] y;
        logic       zero;
        logic       trunc;
    } exp_t;

    exp_t   sb[$];
    longint acc_num = 0;
    longint acc_den = 0;
    int     acc_cnt = 0;

    centroid_defuzz #(.MAX_TERMS(16), .DIV_BITS(9)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mu(in_mu), .in_z(in_z), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_zero(out_zero), .out_trunc(out_trunc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input longint n, input longint d, input bit tr);
        exp_t   e;
        longint q;
        e.trunc = tr;
        if (d == 0) begin
            e.y = 8'd0;
            e.zero = 1'b1;
        end else begin
            e.zero = 1'b0;
            q = ((n < 0) ? -n : n) / d;
            if (n < 0) begin
                if (q > 128) q = 128;
                e.y = 8'(-q);
            end else begin
                if (q > 127) q = 127;
                e.y = 8'(q);
            end
        end
        return e;
    endfunction

    task automatic send_term(input logic [15:0] mu, input logic signed [7:0] z, input logic last);
        int unsigned w;
        longint m;
        @(negedge clk);
        in_valid = 1'b1; in_mu = mu; in_z = z; in_last = last;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        m = (mu > 16'h7FFF) ? 64'sd32767 : longint'(mu);
        acc_num += m * longint'(z);
        acc_den += m;
        acc_cnt++;
        if (last || acc_cnt == 16) begin
            sb.push_back(model(acc_num, acc_den, !last));
            acc_num = 0; acc_den = 0; acc_cnt = 0;
        end
        #1;
        in_valid = 1'b0;
        in_mu = 16'($urandom);
        in_z = 8'($urandom);
        in_last = 1'($urandom);
    endtask

    task automatic wait_out(output bit ok);
        int unsigned w = 0;
        while (!out_valid && w < 200) begin
            @(negedge clk);
            w++;
        end
        ok = out_valid;
    endtask

    task automatic pop_exp(output exp_t e);
        if (sb.size() > 0) e = sb.pop_front();
        else begin e.y = 8'hxx; e.zero = 1'bx; e.trunc = 1'bx; end
    endtask

    task automatic accept_out;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        #3;
        checks += 5;
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        if (out_y !== 8'd0)     begin errors++; $display("FAIL reset_out_y: got %0d want 0", out_y); end
        if (out_zero !== 1'b0)  begin errors++; $display("FAIL reset_out_zero: got %0b want 0", out_zero); end
        if (out_trunc !== 1'b0) begin errors++; $display("FAIL reset_out_trunc: got %0b want 0", out_trunc); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_term(input string name);
        bit ok;
        int hs;
        exp_t e;
        send_term(16'h7FFF, 8'sd50, 1'b1);
        hs = cyc;
        wait_out(ok);
        pop_exp(e);
        checks += 5;
        if (!ok) begin errors++; $display("FAIL %s_valid: timeout, out_valid=%0b", name, out_valid); end
        if (cyc - hs !== 10) begin errors++; $display("FAIL %s_latency: got %0d edges want 10", name, cyc - hs); end
        if (out_y !== e.y || e.y !== 8'd50) begin errors++; $display("FAIL %s_y: got %0d want 50", name, $signed(out_y)); end
        if (out_zero !== 1'b0) begin errors++; $display("FAIL %s_zero: got %0b want 0", name, out_zero); end
        if (out_trunc !== 1'b0) begin errors++; $display("FAIL %s_trunc: got %0b want 0", name, out_trunc); end
        accept_out();
    endtask

    task automatic test_frame(input string name, input logic [7:0] want_y, input logic want_zero, input logic want_trunc);
        bit ok;
        exp_t e;
        wait_out(ok);
        pop_exp(e);
        checks += 4;
        if (!ok) begin errors++; $display("FAIL %s_valid: timeout, out_valid=%0b", name, out_valid); end
        if (out_y !== e.y || out_y !== want_y)
            begin errors++; $display("FAIL %s_y: got %0d want %0d", name, $signed(out_y), $signed(want_y)); end
        if (out_zero !== e.zero || out_zero !== want_zero)
            begin errors++; $display("FAIL %s_zero: got %0b want %0b", name, out_zero, want_zero); end
        if (out_trunc !== e.trunc || out_trunc !== want_trunc)
            begin errors++; $display("FAIL %s_trunc: got %0b want %0b", name, out_trunc, want_trunc); end
        accept_out();
    endtask

    task automatic test_truncation;
        bit ok;
        for (int i = 0; i < 16; i++) send_term(16'h7FFF, 8'sd127, 1'b0);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL trunc_in_ready: got %0b want 0", in_ready); end
        test_frame("t5", 8'd127, 1'b0, 1'b1);
    endtask

    task automatic test_backpressure;
        bit ok;
        exp_t e;
        send_term(16'h7FFF, -8'sd40, 1'b1);
        wait_out(ok);
        pop_exp(e);
        checks++;
        if (!ok) begin errors++; $display("FAIL t6_valid: timeout, out_valid=%0b", out_valid); end
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_mu = 16'h7FFF; in_z = 8'd100; in_last = 1'b1;
            @(negedge clk);
            checks += 3;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL t6_hold_valid[%0d]: got %0b want 1", i, out_valid); end
            if (out_y !== e.y || e.y !== 8'hD8) begin errors++; $display("FAIL t6_hold_y[%0d]: got %0d want -40", i, $signed(out_y)); end
            if (in_ready !== 1'b0) begin errors++; $display("FAIL t6_in_ready[%0d]: got %0b want 0", i, in_ready); end
        end
        in_valid = 1'b0;
        accept_out();
        @(negedge clk);
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL t6_release_valid: got %0b want 0", out_valid); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL t6_release_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_reset_mid_divide;
        exp_t e;
        send_term(16'h7FFF, 8'sd90, 1'b1);
        pop_exp(e);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL t7_out_valid: got %0b want 0", out_valid); end
        if (out_y !== 8'd0)     begin errors++; $display("FAIL t7_out_y: got %0d want 0", out_y); end
        if (out_zero !== 1'b0)  begin errors++; $display("FAIL t7_out_zero: got %0b want 0", out_zero); end
        if (out_trunc !== 1'b0) begin errors++; $display("FAIL t7_out_trunc: got %0b want 0", out_trunc); end
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL t7_in_ready: got %0b want 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL t7_no_output[%0d]: got %0b want 0", i, out_valid); end
        end
        test_single_term("t7_t1");
    endtask

    task automatic test_random_frames;
        bit ok;
        exp_t e;
        int n;
        for (int f = 0; f < 8; f++) begin
            n = $urandom_range(1, 5);
            for (int t = 0; t < n; t++)
                send_term(16'($urandom), 8'($urandom), (t == n - 1));
            wait_out(ok);
            pop_exp(e);
            checks += 4;
            if (!ok) begin errors++; $display("FAIL rand%0d_valid: timeout", f); end
            if (out_y !== e.y) begin errors++; $display("FAIL rand%0d_y: got %0d want %0d", f, $signed(out_y), $signed(e.y)); end
            if (out_zero !== e.zero) begin errors++; $display("FAIL rand%0d_zero: got %0b want %0b", f, out_zero, e.zero); end
            if (out_trunc !== e.trunc) begin errors++; $display("FAIL rand%0d_trunc: got %0b want %0b", f, out_trunc, e.trunc); end
            accept_out();
        end
    endtask

    initial begin
        test_reset();
        test_single_term("t1");
        send_term(16'h4000, -8'sd10, 1'b0);
        send_term(16'h4000, 8'sd20, 1'b1);
        test_frame("t2", 8'd5, 1'b0, 1'b0);
        send_term(16'h4000, -8'sd3, 1'b0);
        send_term(16'h4000, -8'sd4, 1'b1);
        test_frame("t3", 8'hFD, 1'b0, 1'b0);
        send_term(16'h0000, 8'sd10, 1'b0);
        send_term(16'h0000, -8'sd20, 1'b0);
        send_term(16'h0000, 8'sd30, 1'b1);
        test_frame("t4", 8'd0, 1'b1, 1'b0);
        send_term(16'hFFFF, -8'sd128, 1'b1);
        test_frame("clamp_neg", 8'h80, 1'b0, 1'b0);
        test_truncation();
        test_backpressure();
        test_reset_mid_divide();
        test_random_frames();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
